// File: rtl/dtc_feature_framer_if.sv
// Serial feature stream plus result link of the dtc feature framer.
// The framer attaches as slave; the feature source / result consumer side is master.
interface dtc_feature_framer_if #(
    parameter int N_FEAT = 11,
    parameter int N_CLS  = 3
);
    logic              s_valid;
    logic              s_bit;
    logic              s_ready;
    logic              m_valid;
    logic [N_CLS-1:0]  m_label;
    logic [N_FEAT-1:0] m_feat;
    logic              m_ready;

    modport master (
        output s_valid, s_bit, m_ready,
        input  s_ready, m_valid, m_label, m_feat
    );

    modport slave (
        input  s_valid, s_bit, m_ready,
        output s_ready, m_valid, m_label, m_feat
    );
endinterface

// File: rtl/dtc_feature_framer.sv
// Collects an LSB-first serial feature vector, drives it into a combinational dtc_* classifier
// and returns the label on a valid/ready port. Define CLASS_HIST_EN for per-class result counters.
module dtc_feature_framer #(
    parameter int N_FEAT = 11,
    parameter int N_CLS  = 3
`ifdef CLASS_HIST_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    dtc_feature_framer_if.slave link,
    output logic [N_FEAT-1:0]   cls_feat,
    input  logic [N_CLS-1:0]    cls_label
`ifdef CLASS_HIST_EN
    ,
    input  logic [N_CLS-1:0]    hist_sel,
    output logic [CNT_W-1:0]    hist_cnt
`endif
);
    localparam int            BW       = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N_FEAT - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [N_FEAT-1:0] feat_q,    feat_d;
    logic [N_FEAT-1:0] m_feat_q,  m_feat_d;
    logic [N_CLS-1:0]  m_label_q, m_label_d;
    logic              m_valid_q, m_valid_d;
    logic              s_ready_q, s_ready_d;
    logic              bit_acc;

    // s_ready_q is only ever high in COLLECT, so it alone qualifies a bit acceptance.
    assign bit_acc = link.s_valid && s_ready_q && !flush;

    // Next-state and next-output logic; flush overrides every state's own transition.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        feat_d    = feat_q;
        m_feat_d  = m_feat_q;
        m_label_d = m_label_q;
        m_valid_d = m_valid_q;
        s_ready_d = s_ready_q;
        if (flush) begin
            state_d   = COLLECT;
            bit_cnt_d = '0;
            m_valid_d = 1'b0;
            s_ready_d = 1'b1;
        end else begin
            case (state_q)
                COLLECT: begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    if (bit_acc) begin
                        feat_d[bit_cnt_q] = link.s_bit;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = EVAL;
                            s_ready_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                EVAL: begin
                    m_label_d = cls_label;
                    m_feat_d  = feat_q;
                    m_valid_d = 1'b1;
                    s_ready_d = 1'b0;
                    state_d   = HOLD;
                end
                HOLD: begin
                    // No bypass: s_ready comes back the cycle after the result is taken.
                    if (link.m_ready) begin
                        state_d   = COLLECT;
                        m_valid_d = 1'b0;
                        s_ready_d = 1'b1;
                    end else begin
                        m_valid_d = 1'b1;
                        s_ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = COLLECT;
                    bit_cnt_d = '0;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            bit_cnt_q <= '0;
            feat_q    <= '0;
            m_feat_q  <= '0;
            m_label_q <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            feat_q    <= feat_d;
            m_feat_q  <= m_feat_d;
            m_label_q <= m_label_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign cls_feat     = feat_q;
    assign link.s_ready = s_ready_q;
    assign link.m_valid = m_valid_q;
    assign link.m_label = m_label_q;
    assign link.m_feat  = m_feat_q;

`ifdef CLASS_HIST_EN
    localparam int N_BINS = 2 ** N_CLS;

    logic [CNT_W-1:0] hist_q [N_BINS];
    logic             res_taken;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // A flushed HOLD does not deliver its result, so it is not counted.
    assign res_taken = m_valid_q && link.m_ready && !flush;

    // Per-class saturating result counters, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BINS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (res_taken) begin
            hist_q[m_label_q] <= sat_inc(hist_q[m_label_q]);
        end
    end

    assign hist_cnt = hist_q[hist_sel];
`endif
endmodule
